// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Optional macro UART_ARB_FIXED_PRIORITY_EN: lowest asserted index always wins.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FRAME_BITS = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [7:0]             baud_division,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BIT_W = $clog2(FRAME_BITS) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, START_HOLD, WAIT} state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    state_t           state;
    logic [7:0]       bd_q;
    logic [8:0]       period_cnt;
    logic [BIT_W-1:0] bit_cnt;
    pick_t            pick;
    logic [7:0]       pick_byte;
    logic             period_wrap;

    // P-1 = 2*bd+1, so the wrap compare needs no multiplier
    assign period_wrap = (period_cnt == {bd_q, 1'b1});
    assign busy        = (state != IDLE);

`ifdef UART_ARB_FIXED_PRIORITY_EN
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick.valid = 1'b1;
                pick.idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    int               scan;

    always_comb begin
        pick = '0;
        scan = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = int'(rr_ptr) + i;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            if (!pick.valid && req[IDX_W'(scan)]) begin
                pick.valid = 1'b1;
                pick.idx   = IDX_W'(scan);
            end
        end
    end
`endif

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick.idx) pick_byte = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            bd_q       <= '0;
            period_cnt <= '0;
            bit_cnt    <= '0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
            rr_ptr     <= '0;
`endif
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (enable && pick.valid) begin
                        grant      <= NUM_REQ'(1) << pick.idx;
                        tx_data    <= pick_byte;
                        tx_start   <= 1'b1;
                        bd_q       <= baud_division;
                        period_cnt <= '0;
                        bit_cnt    <= '0;
                        state      <= START_HOLD;
`ifndef UART_ARB_FIXED_PRIORITY_EN
                        rr_ptr     <= (pick.idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick.idx + 1'b1;
`endif
                    end
                end
                START_HOLD: begin
                    if (period_wrap) begin
                        period_cnt <= '0;
                        bit_cnt    <= BIT_W'(1);
                        tx_start   <= 1'b0;
                        state      <= WAIT;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // bit_cnt runs 1..FRAME_BITS-1 here: the start hold was period 0
                    if (period_wrap) begin
                        period_cnt <= '0;
                        if (bit_cnt == LAST_BIT) state <= IDLE;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, FRAME_BITS=32).
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic [7:0]     baud_division;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           busy;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.NUM_REQ(N), .FRAME_BITS(32)) dut (
        .clock(clock), .reset(reset), .enable(enable), .baud_division(baud_division),
        .req(req), .req_data(req_data), .grant(grant), .tx_data(tx_data),
        .tx_start(tx_start), .busy(busy)
    );

    task automatic do_reset();
        reset = 1'b1; req = '0; enable = 1'b1; baud_division = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int max, output int n, output logic [N-1:0] g);
        n = 0; g = '0;
        while (n < max && g == '0) begin
            @(negedge clock);
            n++;
            g = grant;
        end
    endtask

    // Called on the grant cycle; counts tx_start/busy cycles until the next grant or max.
    task automatic measure_frame(input int max, output int ts, output int bz,
                                 output int gap, output logic [N-1:0] g);
        int n;
        ts = int'(tx_start); bz = int'(busy); gap = 0; g = '0; n = 0;
        while (n < max && g == '0) begin
            @(negedge clock);
            n++;
            if (grant != '0) begin
                g = grant; gap = n;
            end else begin
                ts += int'(tx_start); bz += int'(busy);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req = '1; baud_division = 8'd0;
        req_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clock);
        checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else passed++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
        checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_single();
        int n, ts, bz, gap;
        logic [N-1:0] g;
        do_reset();
        req_data = 32'h0_0A5_0000 | 32'h00A5_0000;
        req = 4'b0100;
        wait_grant(5, n, g);
        checks++; if (g !== 4'b0100 || n != 1) $display("FAIL single_grant: got %b after %0d want 0100 after 1", g, n); else passed++;
        checks++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", tx_data); else passed++;
        @(negedge clock);
        checks++; if (grant !== 4'b0000) $display("FAIL single_pulse: got %b want 0000", grant); else passed++;
        // re-enter measurement one cycle late: add back the grant cycle by hand
        measure_frame(200, ts, bz, gap, g);
        checks++; if (ts + 1 != 2) $display("FAIL single_tx_start_len: got %0d want 2", ts + 1); else passed++;
        checks++; if (bz + 1 != 64) $display("FAIL single_busy_len: got %0d want 64", bz + 1); else passed++;
        checks++; if (gap + 1 != 65 || g !== 4'b0100) $display("FAIL single_spacing: got %0d/%b want 65/0100", gap + 1, g); else passed++;
        checks++; if (tx_data !== 8'hA5) $display("FAIL single_data_stable: got %h want a5", tx_data); else passed++;
        req = '0;
    endtask

    task automatic test_round_robin();
        int n, ts, bz, gap;
        logic [N-1:0] g;
        logic [7:0] bytes [4];
        int exp_i [5];
        bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
`ifdef UART_ARB_FIXED_PRIORITY_EN
        exp_i = '{0, 0, 0, 0, 0};
`else
        exp_i = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        baud_division = 8'd1;
        req_data = 32'h4332_2110;
        req = 4'b1111;
        wait_grant(5, n, g);
        checks++; if (g !== (4'b0001 << exp_i[0])) $display("FAIL rr_grant0: got %b want idx %0d", g, exp_i[0]); else passed++;
        for (int k = 1; k < 5; k++) begin
            measure_frame(300, ts, bz, gap, g);
            checks++;
            if (g !== (4'b0001 << exp_i[k]) || gap != 129 || tx_data !== bytes[exp_i[k]])
                $display("FAIL rr_grant%0d: got %b gap %0d data %h want idx %0d gap 129 data %h",
                         k, g, gap, tx_data, exp_i[k], bytes[exp_i[k]]);
            else passed++;
        end
        req = '0;
    endtask

    task automatic test_baud_change();
        int n, ts, bz, gap;
        logic [N-1:0] g;
        do_reset();
        baud_division = 8'd3;
        req_data = 32'h0000_005A;
        req = 4'b0001;
        wait_grant(5, n, g);
        checks++; if (g !== 4'b0001) $display("FAIL bd_grant: got %b want 0001", g); else passed++;
        baud_division = 8'd0;
        measure_frame(400, ts, bz, gap, g);
        checks++; if (ts != 8) $display("FAIL bd_tx_start_len: got %0d want 8", ts); else passed++;
        checks++; if (bz != 256) $display("FAIL bd_busy_len: got %0d want 256", bz); else passed++;
        checks++; if (gap != 257 || g !== 4'b0001) $display("FAIL bd_spacing: got %0d/%b want 257/0001", gap, g); else passed++;
        measure_frame(200, ts, bz, gap, g);
        checks++; if (ts != 2 || bz != 64 || gap != 65) $display("FAIL bd_next_frame: got ts %0d busy %0d gap %0d want 2 64 65", ts, bz, gap); else passed++;
        req = '0;
    endtask

    task automatic test_enable();
        int n, ts, bz, gap, seen;
        logic [N-1:0] g;
        do_reset();
        enable = 1'b0;
        req_data = 32'h0000_6600;
        req = 4'b0010;
        seen = 0;
        repeat (100) begin
            @(negedge clock);
            if (grant != '0 || busy) seen++;
        end
        checks++; if (seen != 0) $display("FAIL enable_low_blocks: got %0d active cycles want 0", seen); else passed++;
        enable = 1'b1;
        @(negedge clock);
        checks++; if (grant !== 4'b0010) $display("FAIL enable_rise_grant: got %b want 0010", grant); else passed++;
        enable = 1'b0;
        measure_frame(150, ts, bz, gap, g);
        checks++; if (bz != 64 || ts != 2) $display("FAIL enable_drop_frame: got busy %0d ts %0d want 64 2", bz, ts); else passed++;
        checks++; if (gap != 0) $display("FAIL enable_drop_no_regrant: got grant %b at %0d want none", g, gap); else passed++;
        enable = 1'b1; req = '0;
    endtask

    task automatic test_reset_mid();
        int n, ts, bz, gap;
        logic [N-1:0] g;
        do_reset();
        req_data = 32'h3C00_6600;
        req = 4'b0010;
        wait_grant(5, n, g);
        req = '0;
        repeat (10) @(negedge clock);
        checks++; if (busy !== 1'b1 || tx_start !== 1'b0) $display("FAIL midreset_in_wait: got busy %b ts %b want 1 0", busy, tx_start); else passed++;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || grant !== 4'b0000)
            $display("FAIL midreset_clear: got busy %b ts %b data %h grant %b want 0 0 00 0000", busy, tx_start, tx_data, grant);
        else passed++;
        reset = 1'b0;
        req = 4'b1010;
        wait_grant(5, n, g);
        checks++; if (g !== 4'b0010 || n != 1) $display("FAIL midreset_ptr_cleared: got %b after %0d want 0010 after 1", g, n); else passed++;
        req = 4'b1000;
        measure_frame(200, ts, bz, gap, g);
        checks++; if (g !== 4'b1000 || gap != 65 || tx_data !== 8'h3C) $display("FAIL midreset_req3: got %b gap %0d data %h want 1000 65 3c", g, gap, tx_data); else passed++;
        req = '0;
    endtask

    task automatic test_withdraw();
        int n, ts, bz, gap;
        logic [N-1:0] g;
        do_reset();
        req_data = 32'h0000_2211;
        req = 4'b0010;
        wait_grant(5, n, g);
        checks++; if (g !== 4'b0010) $display("FAIL withdraw_serve1: got %b want 0010", g); else passed++;
        req = 4'b0001;
        repeat (20) @(negedge clock);
        req = '0;
        measure_frame(150, ts, bz, gap, g);
        checks++; if (gap != 0) $display("FAIL withdraw_no_grant: got %b at %0d want none", g, gap); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL withdraw_idle: got busy %b want 0", busy); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b1; baud_division = '0; req = '0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_baud_change();
        test_enable();
        test_reset_mid();
        test_withdraw();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
